// File: rtl/if_prefetch_buf.sv
// Fetch stage: requests aligned 64-bit doublewords and queues 32-bit instructions for decode.
// Latency: one cycle from a completed beat to inst_valid_o (zero with IF_BYPASS_EN on an empty FIFO).
// Backpressure: a request is issued only with >= 2 free slots; decode stalls via inst_ready_i.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   axi_valid_o/ready_i fetch request handshake; axi_addr_o/axi_size_o request fields
//   axi_data_read_i     fetched doubleword; axi_resp_i 2'b00 OKAY, else error
//   pc_jmp_i/jmpaddr_i  redirect pulse and target
//   inst_valid_o/ready_i decode handshake; inst_o, pc_o, pc_pred_o, fault_o head entry
//
// Optional macro IF_BYPASS_EN: forward the first instruction of a beat straight
// to the decode outputs when the FIFO is empty.
module if_prefetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        axi_valid_o,
   input  logic        axi_ready_i,
   output logic [63:0] axi_addr_o,
   output logic [1:0]  axi_size_o,
   input  logic [63:0] axi_data_read_i,
   input  logic [1:0]  axi_resp_i,
   input  logic        pc_jmp_i,
   input  logic [63:0] pc_jmpaddr_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o,
   output logic [63:0] pc_pred_o,
   output logic        fault_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        fault;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [63:0]    fetch_pc_q;
   logic [63:0]    addr_q;
   logic           halted_q;
   logic [CW-1:0]  count_q;
   logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
   entry_t         mem [DEPTH];

   logic [CW-1:0]  free_slots;
   logic           issue;
   logic           beat, beat_ok, beat_err;
   entry_t         e0, e1, w0, head;
   logic [1:0]     n_beat, push_n;
   logic           byp_vld, byp_take;
   logic           head_vld, pop, fifo_pop;
   logic [CW-1:0]  count_d;

   assign free_slots = CW'(DEPTH) - count_q;

   // A request needs room for a full doubleword; pops in flight only add room.
   assign issue    = (state_q == S_IDLE) && !halted_q && (free_slots >= CW'(2));

   // A beat that completes while a jump arrives is dropped.
   assign beat     = (state_q == S_BUSY) && axi_ready_i && !pc_jmp_i;
   assign beat_ok  = beat && (axi_resp_i == 2'b00);
   assign beat_err = beat && (axi_resp_i != 2'b00);

   // Candidate entries produced by the current beat.
   always_comb begin
      e0 = '0;
      e1 = '0;
      n_beat = 2'd0;
      e1.pc    = fetch_pc_q + 64'd4;
      e1.inst  = axi_data_read_i[63:32];
      e1.fault = 1'b0;
      e0.pc    = fetch_pc_q;
      if (beat_err) begin
         e0.inst  = 32'h0000_0013;
         e0.fault = 1'b1;
         n_beat   = 2'd1;
      end else if (beat_ok) begin
         e0.fault = 1'b0;
         if (fetch_pc_q[2]) begin
            // Odd word entry point: only the upper instruction is live.
            e0.inst = axi_data_read_i[63:32];
            n_beat  = 2'd1;
         end else begin
            e0.inst = axi_data_read_i[31:0];
            n_beat  = 2'd2;
         end
      end
   end

`ifdef IF_BYPASS_EN
   assign byp_vld = beat_ok && (count_q == '0);
`else
   assign byp_vld = 1'b0;
`endif

   assign head_vld = (count_q != '0) || byp_vld;
   assign head     = (count_q != '0) ? mem[rd_ptr_q] : e0;
   assign pop      = head_vld && inst_ready_i;
   assign fifo_pop = pop && (count_q != '0);
   assign byp_take = pop && byp_vld;

   // A bypassed instruction that decode takes immediately is never written.
   always_comb begin
      w0     = e0;
      push_n = n_beat;
      if (byp_take) begin
         w0     = e1;
         push_n = n_beat - 2'd1;
      end
   end

   always_comb begin
      if (pc_jmp_i) count_d = '0;
      else          count_d = count_q + CW'(push_n) - CW'(fifo_pop);
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (issue) state_d = S_BUSY;
         S_BUSY: begin
            if (axi_ready_i)   state_d = S_IDLE;
            else if (pc_jmp_i) state_d = S_DISCARD;
         end
         S_DISCARD: if (axi_ready_i) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. The address is latched at issue so it stays stable even
   // after a jump moves fetch_pc while the request is still outstanding.
   always_comb begin
      axi_valid_o = (state_q != S_IDLE);
      axi_addr_o  = addr_q;
      axi_size_o  = 2'b11;
   end

   // Fetch PC, request address, halt flag, FIFO bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         halted_q   <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         if (issue) begin
            addr_q <= pc_jmp_i ? {pc_jmpaddr_i[63:3], 3'b000}
                               : {fetch_pc_q[63:3], 3'b000};
         end
         if (pc_jmp_i) begin
            fetch_pc_q <= {pc_jmpaddr_i[63:2], 2'b00};
            halted_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
         end else begin
            if (beat_ok)  fetch_pc_q <= {fetch_pc_q[63:3] + 61'd1, 3'b000};
            if (beat_err) halted_q   <= 1'b1;
            if (fifo_pop) rd_ptr_q   <= rd_ptr_q + PW'(1);
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
         end
         count_q <= count_d;
      end
   end

   // Storage is not reset; the outputs are gated by inst_valid_o.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) mem[wr_ptr_q] <= w0;
      if (push_n == 2'd2) mem[wr_ptr_q + PW'(1)] <= e1;
   end

   assign inst_valid_o = head_vld;
   assign inst_o       = head_vld ? head.inst  : 32'd0;
   assign pc_o         = head_vld ? head.pc    : 64'd0;
   assign fault_o      = head_vld ? head.fault : 1'b0;
   assign pc_pred_o    = pc_o + 64'd4;

endmodule

// File: tb/tb_if_prefetch_buf.sv
module tb_if_prefetch_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        axi_valid_o;
   logic        axi_ready_i = 1'b0;
   logic [63:0] axi_addr_o;
   logic [1:0]  axi_size_o;
   logic [63:0] axi_data_read_i = '0;
   logic [1:0]  axi_resp_i = 2'b00;
   logic        pc_jmp_i = 1'b0;
   logic [63:0] pc_jmpaddr_i = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] inst_o;
   logic [63:0] pc_o;
   logic [63:0] pc_pred_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_prefetch_buf dut (
      .clk(clk), .rst(rst),
      .axi_valid_o(axi_valid_o), .axi_ready_i(axi_ready_i),
      .axi_addr_o(axi_addr_o), .axi_size_o(axi_size_o),
      .axi_data_read_i(axi_data_read_i), .axi_resp_i(axi_resp_i),
      .pc_jmp_i(pc_jmp_i), .pc_jmpaddr_i(pc_jmpaddr_i),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
      .inst_o(inst_o), .pc_o(pc_o), .pc_pred_o(pc_pred_o), .fault_o(fault_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                           input logic fault);
      chk({tag, "_vld"},   64'(inst_valid_o), 64'd1);
      chk({tag, "_pc"},    pc_o, pc);
      chk({tag, "_inst"},  64'(inst_o), 64'(inst));
      chk({tag, "_fault"}, 64'(fault_o), 64'(fault));
      chk({tag, "_pred"},  pc_pred_o, pc + 64'd4);
   endtask

   task automatic chk_req(input string tag, input logic [63:0] addr);
      chk({tag, "_avld"}, 64'(axi_valid_o), 64'd1);
      chk({tag, "_addr"}, axi_addr_o, addr);
   endtask

   logic [63:0] h, base;
   logic [31:0] prev_hi;
   logic [63:0] d;

   initial begin
      // ---------------- reset state ----------------
      #1 rst = 1'b1;
      #2;
      chk("rst_avld",  64'(axi_valid_o), 64'd0);
      chk("rst_addr",  axi_addr_o, 64'd0);
      chk("rst_size",  64'(axi_size_o), 64'd3);
      chk("rst_ivld",  64'(inst_valid_o), 64'd0);
      chk("rst_inst",  64'(inst_o), 64'd0);
      chk("rst_pc",    pc_o, 64'd0);
      chk("rst_pred",  pc_pred_o, 64'd4);
      chk("rst_fault", 64'(fault_o), 64'd0);
      tick(); tick();
      rst = 1'b0;

      // ---------------- first fetch ----------------
      tick();
      chk_req("req0", 64'h8000_0000);
      chk("req0_ivld", 64'(inst_valid_o), 64'd0);
      axi_ready_i = 1'b1; axi_data_read_i = 64'h00a0_0093_0010_0113;
      tick();
      axi_ready_i = 1'b0;
      chk_head("beat0", 64'h8000_0000, 32'h0010_0113, 1'b0);
      chk("beat0_avld", 64'(axi_valid_o), 64'd0);

      // ---------------- fill to DEPTH ----------------
      tick();
      chk_req("req1", 64'h8000_0008);
      tick();
      chk_req("req1_hold", 64'h8000_0008);
      axi_ready_i = 1'b1; axi_data_read_i = 64'h0000_0513_0050_0593;
      tick();
      axi_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("full_noreq", 64'(axi_valid_o), 64'd0);
         tick();
      end
      chk_head("full_head", 64'h8000_0000, 32'h0010_0113, 1'b0);
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      chk_head("pop1", 64'h8000_0004, 32'h00a0_0093, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("free1_noreq", 64'(axi_valid_o), 64'd0);
         tick();
      end
      chk("free1_noreq", 64'(axi_valid_o), 64'd0);
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      chk_head("pop2", 64'h8000_0008, 32'h0050_0593, 1'b0);
      chk("pop2_avld", 64'(axi_valid_o), 64'd0);
      tick();
      chk_req("req2", 64'h8000_0010);

      // ---------------- error response ----------------
      axi_ready_i = 1'b1; axi_resp_i = 2'b10; axi_data_read_i = 64'hffff_ffff_ffff_ffff;
      tick();
      axi_ready_i = 1'b0; axi_resp_i = 2'b00;
      inst_ready_i = 1'b1;
      tick();
      chk_head("err_pop1", 64'h8000_000c, 32'h0000_0513, 1'b0);
      tick();
      inst_ready_i = 1'b0;
      chk_head("err_head", 64'h8000_0010, 32'h0000_0013, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("halt_noreq", 64'(axi_valid_o), 64'd0);
         tick();
      end
      pc_jmp_i = 1'b1; pc_jmpaddr_i = 64'h8000_0000;
      tick();
      pc_jmp_i = 1'b0;
      chk("jmp0_ivld",  64'(inst_valid_o), 64'd0);
      chk("jmp0_fault", 64'(fault_o), 64'd0);
      tick();
      chk_req("req3", 64'h8000_0000);

      // ---------------- jump while BUSY ----------------
      pc_jmp_i = 1'b1; pc_jmpaddr_i = 64'h8000_0104;
      tick();
      pc_jmp_i = 1'b0;
      chk_req("disc0", 64'h8000_0000);
      tick();
      tick();
      chk_req("disc2", 64'h8000_0000);
      axi_ready_i = 1'b1; axi_data_read_i = 64'hdead_beef_cafe_f00d;
      tick();
      axi_ready_i = 1'b0;
      chk("drop_ivld", 64'(inst_valid_o), 64'd0);
      chk("drop_avld", 64'(axi_valid_o), 64'd0);
      tick();
      chk_req("req4", 64'h8000_0100);
      axi_ready_i = 1'b1; axi_data_read_i = 64'h0040_0213_0030_0193;
      tick();
      axi_ready_i = 1'b0;
      chk_head("odd", 64'h8000_0104, 32'h0040_0213, 1'b0);

      // ---------------- pop + 2-entry push at count 2, across wrap ----------------
      tick();
      chk_req("req5", 64'h8000_0108);
      axi_ready_i = 1'b1; axi_data_read_i = 64'h1111_0002_1111_0001;
      tick();
      axi_ready_i = 1'b0;
      chk_head("fill3", 64'h8000_0104, 32'h0040_0213, 1'b0);
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      chk_head("cnt2", 64'h8000_0108, 32'h1111_0001, 1'b0);
      tick();
      chk_req("req6", 64'h8000_0110);
      h = 64'h8000_0108; base = 64'h8000_0110; prev_hi = 32'h1111_0002;
      for (int k = 0; k < 3; k++) begin
         d = {32'hA000_0001 + 32'(2 * k), 32'hA000_0000 + 32'(2 * k)};
         axi_ready_i = 1'b1; inst_ready_i = 1'b1; axi_data_read_i = d;
         tick();
         axi_ready_i = 1'b0;
         chk_head("wrap_a", h + 64'd4, prev_hi, 1'b0);
         tick();
         inst_ready_i = 1'b0;
         chk_head("wrap_b", base, 32'hA000_0000 + 32'(2 * k), 1'b0);
         tick();
         chk_req("wrap_c", base + 64'd8);
         prev_hi = 32'hA000_0001 + 32'(2 * k);
         h = h + 64'd8;
         base = base + 64'd8;
      end

      // ---------------- reset mid-BUSY ----------------
      #2 rst = 1'b1;
      #1;
      chk("mrst_avld", 64'(axi_valid_o), 64'd0);
      chk("mrst_ivld", 64'(inst_valid_o), 64'd0);
      chk("mrst_addr", axi_addr_o, 64'd0);
      chk("mrst_pred", pc_pred_o, 64'd4);
      tick();
      rst = 1'b0;
      tick();
      chk_req("mrst_req", 64'h8000_0000);
      chk("mrst_ivld2", 64'(inst_valid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
